// File: rtl/iob_countdown_if.sv
// Load handshake, mode controls and count outputs of iob_countdown.
// Signal names match the legacy port names for drop-in compatibility.
interface iob_countdown_if #(
    parameter int unsigned DATA_W = 16
);
    logic              load_valid_i;
    logic              load_ready_o;
    logic [DATA_W-1:0] load_data_i;
    logic              reload_en_i;
    logic              counter_en_i;
    logic [DATA_W-1:0] data_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output load_valid_i, load_data_i, reload_en_i, counter_en_i,
        input  load_ready_o, data_o, busy_o, done_o
    );

    modport slave (
        input  load_valid_i, load_data_i, reload_en_i, counter_en_i,
        output load_ready_o, data_o, busy_o, done_o
    );
endinterface

// File: rtl/iob_countdown.sv
// Loadable down-counter with valid/ready load, terminal-count pulse and
// optional auto-reload; used as a timeout/interval source.
module iob_countdown #(
    parameter int unsigned DATA_W = 16
) (
    input  logic clk_i,
    input  logic cke_i,
    input  logic arst_n_i,
    input  logic counter_rst_i,
    iob_countdown_if.slave ctrl
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    logic [0:0]        state;
    logic [DATA_W-1:0] count;
    logic [DATA_W-1:0] reload_val;
    logic              done;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= IDLE;
            count      <= '0;
            reload_val <= '0;
            done       <= 1'b0;
        end else if (cke_i) begin
            if (counter_rst_i) begin
                state      <= IDLE;
                count      <= '0;
                reload_val <= '0;
                done       <= 1'b0;
            end else begin
                done <= 1'b0;
                case (state)
                    IDLE: begin
                        if (ctrl.load_valid_i) begin
                            count      <= ctrl.load_data_i;
                            reload_val <= ctrl.load_data_i;
                            if (ctrl.load_data_i != '0) begin
                                state <= RUN;
                            end else begin
                                done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (ctrl.counter_en_i) begin
                            if (count > ONE) begin
                                count <= count - ONE;
                            end else begin
                                // Terminal edge: reload mode is sampled only here.
                                done <= 1'b1;
                                if (ctrl.reload_en_i) begin
                                    count <= reload_val;
                                end else begin
                                    count <= '0;
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign ctrl.load_ready_o = (state == IDLE);
    assign ctrl.busy_o       = (state == RUN);
    assign ctrl.data_o       = count;
    assign ctrl.done_o       = done;
endmodule
